// File: rtl/sdr_init_seq.sv
// sdr_init_seq: SDRAM power-up init sequencer (power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE)
//   cfg_sdr_en/trp_d/trcar_d/mode_reg  configuration in; cfg_sdr_en low aborts to IDLE
//   cmd_req/cmd_gnt/cmd_rcw/cmd_addr/cmd_ba  command to the bus arbiter, held until cmd_req && cmd_gnt
//   init_busy/sdr_init_done  sequencer status back to the config master
module sdr_init_seq #(
    parameter int PWRUP_CYCLES = 20000,
    parameter int PWRUP_W      = 16,
    parameter int REF_COUNT    = 2,
    parameter int TMRD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_sdr_en,
    input  logic [3:0]  cfg_sdr_trp_d,
    input  logic [3:0]  cfg_sdr_trcar_d,
    input  logic [12:0] cfg_sdr_mode_reg,
    output logic        cmd_req,
    input  logic        cmd_gnt,
    output logic [2:0]  cmd_rcw,
    output logic [12:0] cmd_addr,
    output logic [1:0]  cmd_ba,
    output logic        init_busy,
    output logic        sdr_init_done
);
    typedef enum logic [3:0] {
        IDLE, PWRUP, PRE_REQ, PRE_WAIT, REF_REQ, REF_WAIT, MRS_REQ, MRS_WAIT, DONE
    } state_t;
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [PWRUP_W-1:0] PWR_LD = PWRUP_W'(PWRUP_CYCLES - 1);
    localparam logic [3:0] TMRD_LD = 4'(TMRD_CYCLES > 1 ? TMRD_CYCLES - 1 : 0);
    localparam logic [3:0] REF_N = 4'(REF_COUNT);
    state_t             state_q;
    logic [PWRUP_W-1:0] pwr_q;
    logic [3:0]         wait_q, ref_q;
    logic               req_q, busy_q, done_q;
    logic [2:0]         rcw_q;
    logic [12:0]        addr_q;
    logic [3:0]         wait_pre_d, wait_ref_d;
    // Wait counters run d'-1 down to 0 so a zero delay still gives one idle cycle.
    always_comb begin
        wait_pre_d = cfg_sdr_trp_d == 4'd0 ? 4'd0 : cfg_sdr_trp_d - 4'd1;
        wait_ref_d = cfg_sdr_trcar_d == 4'd0 ? 4'd0 : cfg_sdr_trcar_d - 4'd1;
    end
    always_ff @(posedge clk) begin
        // Dropping the enable outside IDLE behaves exactly like reset, beating any grant.
        if (reset || (state_q != IDLE && !cfg_sdr_en)) begin
            state_q <= IDLE;
            pwr_q   <= '0;
            wait_q  <= '0;
            ref_q   <= '0;
            req_q   <= 1'b0;
            rcw_q   <= CMD_NOP;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cfg_sdr_en) begin
                    state_q <= PWRUP;
                    pwr_q   <= PWR_LD;
                    ref_q   <= '0;
                    busy_q  <= 1'b1;
                end
                PWRUP: if (pwr_q == '0) begin
                    state_q <= PRE_REQ;
                    req_q   <= 1'b1;
                    rcw_q   <= CMD_PRE;
                    addr_q  <= 13'h400;
                end else pwr_q <= pwr_q - PWRUP_W'(1);
                PRE_REQ: if (cmd_gnt) begin
                    state_q <= PRE_WAIT;
                    wait_q  <= wait_pre_d;
                    req_q   <= 1'b0;
                    rcw_q   <= CMD_NOP;
                    addr_q  <= '0;
                end
                PRE_WAIT: if (wait_q == 4'd0) begin
                    state_q <= REF_REQ;
                    req_q   <= 1'b1;
                    rcw_q   <= CMD_REF;
                end else wait_q <= wait_q - 4'd1;
                REF_REQ: if (cmd_gnt) begin
                    state_q <= REF_WAIT;
                    wait_q  <= wait_ref_d;
                    ref_q   <= ref_q + 4'd1;
                    req_q   <= 1'b0;
                    rcw_q   <= CMD_NOP;
                end
                REF_WAIT: if (wait_q == 4'd0) begin
                    state_q <= ref_q >= REF_N ? MRS_REQ : REF_REQ;
                    req_q   <= 1'b1;
                    rcw_q   <= ref_q >= REF_N ? CMD_MRS : CMD_REF;
                    addr_q  <= ref_q >= REF_N ? cfg_sdr_mode_reg : 13'h0;
                end else wait_q <= wait_q - 4'd1;
                MRS_REQ: if (cmd_gnt) begin
                    state_q <= MRS_WAIT;
                    wait_q  <= TMRD_LD;
                    req_q   <= 1'b0;
                    rcw_q   <= CMD_NOP;
                    addr_q  <= '0;
                end
                MRS_WAIT: if (wait_q == 4'd0) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else wait_q <= wait_q - 4'd1;
                default: ;
            endcase
        end
    end
    assign cmd_req       = req_q;
    assign cmd_rcw       = rcw_q;
    assign cmd_addr      = addr_q;
    assign cmd_ba        = 2'b00;
    assign init_busy     = busy_q;
    assign sdr_init_done = done_q;
endmodule
